fb_pixel_writer: RTL and testbench

- Downstream consumer of the triangle rasteriser's pixel stream (px, py, pixel_color, valid, done). Writes each pixel into a linear framebuffer memory port.
- The rasteriser has no backpressure and emits one-cycle valid pulses. This block therefore buffers them in a small FIFO and drains the FIFO into a memory port that can stall.
- Clips out-of-range pixels and flags FIFO overflow.
- Reports frame completion once the rasteriser is done and every accepted pixel has been committed to memory.

---
 rtl/fb_pixel_writer_pkg.sv | 24 ++
 rtl/fb_pixel_writer_if.sv | 31 +++
 rtl/fb_pixel_writer_pix_fifo.sv | 41 ++++
 rtl/fb_pixel_writer.sv | 147 ++++++++++++++
 tb/tb_fb_pixel_writer.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pixel_writer_pkg.sv
// Shared types and defaults for the framebuffer pixel writer.
package fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_FLUSH = 2'b10,
    ST_DONE  = 2'b11
  } fb_state_t;

  localparam int FB_CORDW_DEF  = 8;
  localparam int FB_W_DEF      = 256;
  localparam int FB_H_DEF      = 256;
  localparam int FB_COLORW_DEF = 24;
  localparam int FB_DEPTH_DEF  = 8;

  // Smallest address width that covers a w x h linear framebuffer.
  function automatic int fb_addr_w(input int w, input int h);
    int n;
    n = w * h;
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fb_pixel_writer_if.sv
// Rasteriser pixel stream and framebuffer write port bundles.
interface fb_pix_if
  import fb_pkg::*;
#(
  parameter int CORDW  = FB_CORDW_DEF,
  parameter int COLORW = FB_COLORW_DEF
);
  logic              pix_valid;
  logic [CORDW-1:0]  pix_x;
  logic [CORDW-1:0]  pix_y;
  logic [COLORW-1:0] pix_color;
  logic              src_done;

  modport master (output pix_valid, pix_x, pix_y, pix_color, src_done);
  modport slave  (input  pix_valid, pix_x, pix_y, pix_color, src_done);
endinterface

interface fb_mem_if
  import fb_pkg::*;
#(
  parameter int ADDRW  = 16,
  parameter int COLORW = FB_COLORW_DEF
);
  logic              mem_we;
  logic [ADDRW-1:0]  mem_addr;
  logic [COLORW-1:0] mem_wdata;
  logic              mem_ready;

  modport master (output mem_we, mem_addr, mem_wdata, input mem_ready);
  modport slave  (input mem_we, mem_addr, mem_wdata, output mem_ready);
endinterface

// File: rtl/fb_pixel_writer_pix_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head word is visible combinationally.
module pix_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_dout  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push && !o_full) begin
        r_mem[r_wptr[AW-1:0]] <= i_din;
        r_wptr                <= r_wptr + 1'b1;
      end
      if (i_pop && !o_empty) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Pixel-stream to framebuffer writer: buffers rasteriser strobes in a FIFO and
// drains them through a stallable memory write port, with clipping and overflow flagging.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int CORDW  = FB_CORDW_DEF,
  parameter int FB_W   = FB_W_DEF,
  parameter int FB_H   = FB_H_DEF,
  parameter int ADDRW  = fb_addr_w(FB_W, FB_H),
  parameter int COLORW = FB_COLORW_DEF,
  parameter int DEPTH  = FB_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  fb_pix_if.slave     pix,
  fb_mem_if.master    mem,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_overflow,
  output logic [15:0] o_clip_cnt,
  output logic [15:0] o_wr_cnt
);
  // state | meaning
  // IDLE  | waiting for start; frame_done still reports the previous frame
  // RUN   | accepting pixels from the rasteriser
  // FLUSH | rasteriser done; draining FIFO and output register
  // DONE  | frame fully committed; waiting for start to fall
  localparam int WORDW = 2 * CORDW + COLORW;

  fb_state_t         r_state;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_overflow;
  logic [15:0]       r_clip_cnt;
  logic [15:0]       r_wr_cnt;
  logic              r_we;
  logic [ADDRW-1:0]  r_addr;
  logic [COLORW-1:0] r_wdata;

  logic              w_start_frame;
  logic              w_in_range;
  logic              w_accept;
  logic              w_push;
  logic              w_drop;
  logic              w_clip;
  logic              w_can_load;
  logic              w_pop;
  logic              w_wr_done;
  logic              w_full;
  logic              w_empty;
  logic [WORDW-1:0]  w_head;
  logic [CORDW-1:0]  w_head_x;
  logic [CORDW-1:0]  w_head_y;
  logic [COLORW-1:0] w_head_color;
  logic [ADDRW-1:0]  w_addr;

  assign w_start_frame = (r_state == ST_IDLE) && i_start;
  assign w_in_range    = (32'(pix.pix_x) < FB_W) && (32'(pix.pix_y) < FB_H);
  assign w_accept      = (r_state == ST_RUN) && pix.pix_valid;
  assign w_clip        = w_accept && !w_in_range;
  // Full is sampled before any pop this cycle, so a same-cycle pop never frees a slot.
  assign w_push        = w_accept && w_in_range && !w_full;
  assign w_drop        = w_accept && w_in_range && w_full;
  assign w_can_load    = !r_we || mem.mem_ready;
  assign w_pop         = w_can_load && !w_empty;
  assign w_wr_done     = r_we && mem.mem_ready;

  assign {w_head_x, w_head_y, w_head_color} = w_head;
  assign w_addr = ADDRW'(w_head_y) * ADDRW'(FB_W) + ADDRW'(w_head_x);

  pix_fifo #(
    .WIDTH (WORDW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_start_frame),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   ({pix.pix_x, pix.pix_y, pix.pix_color}),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_start) begin
          r_state      <= ST_RUN;
          r_busy       <= 1'b1;
          r_frame_done <= 1'b0;
        end
        ST_RUN: if (pix.src_done) r_state <= ST_FLUSH;
        ST_FLUSH: if (w_empty && w_can_load) begin
          r_state      <= ST_DONE;
          r_busy       <= 1'b0;
          r_frame_done <= 1'b1;
        end
        ST_DONE: if (!i_start) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output register: load a new head whenever the current write is absent or accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_pop) begin
      r_we    <= 1'b1;
      r_addr  <= w_addr;
      r_wdata <= w_head_color;
    end else if (w_can_load) begin
      r_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_start_frame) begin
      r_overflow <= 1'b0;
      r_clip_cnt <= '0;
      r_wr_cnt   <= '0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if (w_clip && (r_clip_cnt != 16'hFFFF)) r_clip_cnt <= r_clip_cnt + 16'd1;
      if (w_wr_done && (r_wr_cnt != 16'hFFFF)) r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end

  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;
  assign o_busy        = r_busy;
  assign o_frame_done  = r_frame_done;
  assign o_overflow    = r_overflow;
  assign o_clip_cnt    = r_clip_cnt;
  assign o_wr_cnt      = r_wr_cnt;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Drives two writer instances (256x256 and 200x150) with identical stimulus and
// compares both against a queue-based reference model every cycle.
module tb_fb_pixel_writer;
  import fb_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic        sdone = 1'b0;
  logic        ready = 1'b1;
  logic [7:0]  px = '0;
  logic [7:0]  py = '0;
  logic [23:0] pc = '0;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  int fd_edge = 0;

  logic [1:0]       d_we, d_busy, d_fd, d_ovf;
  logic [1:0][15:0] d_addr, d_clip, d_wr;
  logic [1:0][23:0] d_data;

  fb_pix_if #(.CORDW(8), .COLORW(24)) pif0 ();
  fb_pix_if #(.CORDW(8), .COLORW(24)) pif1 ();
  fb_mem_if #(.ADDRW(16), .COLORW(24)) mif0 ();
  fb_mem_if #(.ADDRW(16), .COLORW(24)) mif1 ();

  assign pif0.pix_valid = valid;  assign pif1.pix_valid = valid;
  assign pif0.pix_x     = px;     assign pif1.pix_x     = px;
  assign pif0.pix_y     = py;     assign pif1.pix_y     = py;
  assign pif0.pix_color = pc;     assign pif1.pix_color = pc;
  assign pif0.src_done  = sdone;  assign pif1.src_done  = sdone;
  assign mif0.mem_ready = ready;  assign mif1.mem_ready = ready;
  assign d_we[0] = mif0.mem_we;   assign d_addr[0] = mif0.mem_addr;  assign d_data[0] = mif0.mem_wdata;
  assign d_we[1] = mif1.mem_we;   assign d_addr[1] = mif1.mem_addr;  assign d_data[1] = mif1.mem_wdata;

  fb_pixel_writer #(.CORDW(8), .FB_W(256), .FB_H(256), .ADDRW(16), .COLORW(24), .DEPTH(DEPTH)) dut0 (
    .clk(clk), .rst(rst), .i_start(start), .pix(pif0), .mem(mif0),
    .o_busy(d_busy[0]), .o_frame_done(d_fd[0]), .o_overflow(d_ovf[0]),
    .o_clip_cnt(d_clip[0]), .o_wr_cnt(d_wr[0]));

  fb_pixel_writer #(.CORDW(8), .FB_W(200), .FB_H(150), .ADDRW(16), .COLORW(24), .DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .i_start(start), .pix(pif1), .mem(mif1),
    .o_busy(d_busy[1]), .o_frame_done(d_fd[1]), .o_overflow(d_ovf[1]),
    .o_clip_cnt(d_clip[1]), .o_wr_cnt(d_wr[1]));

  // Reference model: phase 0 idle, 1 run, 2 flush, 3 done.
  int          m_ph [2];
  bit          m_we [2];
  logic [39:0] m_out [2];
  bit          m_ovf [2];
  bit          m_fd [2];
  int          m_clip [2];
  int          m_wr [2];
  logic [39:0] mq [2][$];
  logic [15:0] wlog [2][$];
  int          last_wr [2];

  function automatic int fbw(int k);
    return (k == 0) ? 256 : 200;
  endfunction

  function automatic int fbh(int k);
    return (k == 0) ? 256 : 150;
  endfunction

  task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  task automatic model_step(int k);
    bit full, empty, can_load, put;
    if (rst) begin
      m_ph[k] = 0; m_we[k] = 0; m_out[k] = '0; m_ovf[k] = 0; m_fd[k] = 0;
      m_clip[k] = 0; m_wr[k] = 0; mq[k].delete();
    end else begin
      full     = (mq[k].size() >= DEPTH);
      empty    = (mq[k].size() == 0);
      can_load = !m_we[k] || ready;
      put      = 0;
      if (m_we[k] && ready && m_wr[k] < 65535) m_wr[k]++;
      if (m_ph[k] == 1 && valid) begin
        if (int'(px) >= fbw(k) || int'(py) >= fbh(k)) begin
          if (m_clip[k] < 65535) m_clip[k]++;
        end else if (full) m_ovf[k] = 1;
        else put = 1;
      end
      if (can_load) begin
        if (!empty) begin m_out[k] = mq[k].pop_front(); m_we[k] = 1; end
        else m_we[k] = 0;
      end
      if (put) mq[k].push_back({16'(int'(py) * fbw(k) + int'(px)), pc});
      case (m_ph[k])
        0: if (start) begin
          m_ph[k] = 1; mq[k].delete(); m_clip[k] = 0; m_wr[k] = 0; m_ovf[k] = 0; m_fd[k] = 0;
        end
        1: if (sdone) m_ph[k] = 2;
        2: if (empty && can_load) begin m_ph[k] = 3; m_fd[k] = 1; end
        default: if (!start) m_ph[k] = 0;
      endcase
    end
  endtask

  task automatic check_outs(int k);
    check_val($sformatf("we%0d", k), d_we[k], m_we[k]);
    if (m_we[k]) begin
      check_val($sformatf("addr%0d", k), d_addr[k], m_out[k][39:24]);
      check_val($sformatf("data%0d", k), d_data[k], m_out[k][23:0]);
    end
    check_val($sformatf("busy%0d", k), d_busy[k], (m_ph[k] == 1 || m_ph[k] == 2));
    check_val($sformatf("fd%0d", k), d_fd[k], m_fd[k]);
    check_val($sformatf("ovf%0d", k), d_ovf[k], m_ovf[k]);
    check_val($sformatf("clip%0d", k), d_clip[k], m_clip[k]);
    check_val($sformatf("wr%0d", k), d_wr[k], m_wr[k]);
  endtask

  // Inputs are applied before the call; the edge consumes them, outputs are checked 1ns later.
  task automatic cycle();
    for (int k = 0; k < 2; k++) begin
      if (d_we[k] && ready && !rst) begin
        wlog[k].push_back(d_addr[k]);
        last_wr[k] = ncyc + 1;
      end
      model_step(k);
    end
    @(posedge clk);
    #1;
    ncyc++;
    for (int k = 0; k < 2; k++) check_outs(k);
  endtask

  task automatic frame_start();
    start = 1'b1;
    wlog[0].delete();
    wlog[1].delete();
    cycle();
  endtask

  task automatic pix(int x, int y, logic [23:0] c);
    valid = 1'b1; px = 8'(x); py = 8'(y); pc = c;
    cycle();
    valid = 1'b0;
  endtask

  task automatic wait_fd(string tag);
    int n;
    n = 0;
    valid = 1'b0; sdone = 1'b1; ready = 1'b1;
    while (!(d_fd[0] && d_fd[1]) && n < 200) begin
      cycle();
      n++;
    end
    check_val({tag, "_fd_timeout"}, (n < 200), 1);
    fd_edge = ncyc;
  endtask

  task automatic end_frame();
    start = 1'b0; sdone = 1'b0;
    cycle();
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_a [8];

    // reset
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    check_val("rst_addr", d_addr[0], 0);
    check_val("rst_data", d_data[0], 0);
    cycle();

    // basic three-pixel frame
    ready = 1'b1;
    frame_start();
    pix(1, 2, 24'hFF0000);
    pix(3, 4, 24'h00FF00);
    pix(5, 0, 24'h0000FF);
    wait_fd("basic");
    check_val("basic_n", wlog[0].size(), 3);
    check_val("basic_a0", wlog[0][0], 513);
    check_val("basic_a1", wlog[0][1], 1027);
    check_val("basic_a2", wlog[0][2], 5);
    check_val("basic_wrcnt", d_wr[0], 3);
    check_val("basic_fd_lat", (fd_edge - last_wr[0] <= 2), 1);
    end_frame();

    // backpressure: 8 pixels, 20-cycle stall
    frame_start();
    ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_a[i] = 16'((i + 10) * 256 + i * 3);
      pix(i * 3, i + 10, 24'($urandom));
    end
    for (int i = 0; i < 20; i++) begin
      cycle();
      check_val("bp_hold_we", d_we[0], 1);
      check_val("bp_hold_addr", d_addr[0], exp_a[0]);
    end
    wait_fd("bp");
    check_val("bp_n", wlog[0].size(), 8);
    for (int i = 0; i < 8; i++) check_val($sformatf("bp_a%0d", i), wlog[0][i], exp_a[i]);
    check_val("bp_ovf", d_ovf[0], 0);
    end_frame();

    // overflow: 10 pixels into a stalled port
    frame_start();
    ready = 1'b0;
    for (int i = 0; i < 10; i++) pix(i, 2 * i, 24'h100 + 24'(i));
    check_val("ovf_flag", d_ovf[0], 1);
    wait_fd("ovf");
    check_val("ovf_wrcnt", d_wr[0], 9);
    check_val("ovf_n", wlog[0].size(), 9);
    end_frame();

    // clipping on the 200x150 instance
    frame_start();
    pix(199, 149, 24'hABCDEF);
    pix(200, 0, 24'h111111);
    pix(0, 150, 24'h222222);
    wait_fd("clip");
    check_val("clip_cnt1", d_clip[1], 2);
    check_val("clip_n1", wlog[1].size(), 1);
    check_val("clip_a1", wlog[1][0], 29999);
    check_val("clip_cnt0", d_clip[0], 0);
    check_val("clip_wr0", d_wr[0], 3);
    end_frame();

    // pixel coinciding with src_done, then a pixel in DONE
    frame_start();
    pix(7, 7, 24'h070707);
    valid = 1'b1; px = 8'd9; py = 8'd9; pc = 24'h090909; sdone = 1'b1;
    cycle();
    valid = 1'b0;
    wait_fd("simul");
    check_val("simul_n", wlog[0].size(), 2);
    check_val("simul_a1", wlog[0][1], 2313);
    valid = 1'b1; px = 8'd11; py = 8'd11;
    cycle();
    valid = 1'b0;
    check_val("done_ignore_wr", d_wr[0], 2);
    end_frame();

    // reset during a stalled write
    frame_start();
    ready = 1'b0;
    pix(1, 1, 24'h010101);
    pix(2, 2, 24'h020202);
    pix(3, 3, 24'h030303);
    cycle();
    check_val("mid_pending", d_we[0], 1);
    rst = 1'b1; start = 1'b0;
    cycle();
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("mid_rst_we%0d", k), d_we[k], 0);
      check_val($sformatf("mid_rst_addr%0d", k), d_addr[k], 0);
      check_val($sformatf("mid_rst_data%0d", k), d_data[k], 0);
      check_val($sformatf("mid_rst_busy%0d", k), d_busy[k], 0);
      check_val($sformatf("mid_rst_wr%0d", k), d_wr[k], 0);
    end
    rst = 1'b0; ready = 1'b1;
    cycle();
    frame_start();
    pix(10, 20, 24'h5A5A5A);
    wait_fd("mid");
    check_val("mid_wr", d_wr[0], 1);
    check_val("mid_a0", wlog[0][0], 5130);
    check_val("mid_ovf", d_ovf[0], 0);
    end_frame();

    // randomized frames, the last one with heavy backpressure
    for (int f = 0; f < 4; f++) begin
      frame_start();
      for (int c = 0; c < 60; c++) begin
        valid = 1'($urandom_range(0, 1));
        px    = 8'($urandom);
        py    = 8'($urandom);
        pc    = 24'($urandom);
        ready = (f == 3) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
        cycle();
      end
      valid = 1'b0;
      wait_fd($sformatf("rnd%0d", f));
      for (int k = 0; k < 2; k++)
        check_val($sformatf("rnd%0d_n%0d", f, k), wlog[k].size(), m_wr[k]);
      end_frame();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
